// File: rtl/dmem_pkg.sv
// Shared types and address-field positions for the banked data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam int unsigned NUM_BANKS     = 4;
  localparam int unsigned ALIGN_BIT     = 0;
  localparam int unsigned BANK_LSB      = 1;
  localparam int unsigned BANK_MSB      = 2;
  localparam int unsigned ROW_LSB       = 3;

  localparam int unsigned DEF_LATENCY   = 2;
  localparam int unsigned DEF_BANK_BUSY = 4;
  localparam int unsigned DEF_ROW_BITS  = 6;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and the responder (slave).
interface dmem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic        createdump;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd, createdump,
    input  data_out, stall, done, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd, createdump,
    output data_out, stall, done, busy, err
  );
endinterface

// File: rtl/dmem_bank.sv
// One memory bank: word array with synchronous write, combinational read and
// a write-recovery counter that keeps the bank busy after each write.
module dmem_bank #(
  parameter int unsigned ROW_BITS  = 6,
  parameter int unsigned BANK_BUSY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ROW_BITS-1:0] row,
  input  logic [15:0]         wdata,
  output logic [15:0]         rdata,
  output logic                busy
);
  localparam int unsigned WORDS = 2 ** ROW_BITS;

  logic [15:0] mem [WORDS];
  logic [3:0]  busy_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem[i[ROW_BITS-1:0]] <= '0;
      end
      busy_cnt <= '0;
    end else begin
      if (we) begin
        mem[row] <= wdata;
        busy_cnt <= 4'(BANK_BUSY);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - 4'd1;
      end
    end
  end

  assign rdata = mem[row];
  assign busy  = (busy_cnt != '0);

endmodule

// File: rtl/dmem_responder.sv
// Banked data-memory responder: request FSM, latency counter, bank decode and
// read-data register in front of four interleaved dmem_bank instances.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY   = DEF_LATENCY,
  parameter int unsigned BANK_BUSY = DEF_BANK_BUSY,
  parameter int unsigned ROW_BITS  = DEF_ROW_BITS
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  state_t              state;
  logic [3:0]          lat_cnt;
  logic [15:0]         data_q;

  logic [1:0]          bank;
  logic [ROW_BITS-1:0] row;
  logic                req;
  logic                illegal;
  logic                legal;
  logic                bank_busy;
  logic                accept;
  logic [NUM_BANKS-1:0] we;
  logic [NUM_BANKS-1:0] busy_vec;
  logic [15:0]         rdata [NUM_BANKS];

  // Address bits above the row field are ignored, so the array aliases.
  assign bank      = bus.addr[BANK_MSB:BANK_LSB];
  assign row       = bus.addr[ROW_LSB+ROW_BITS-1:ROW_LSB];
  assign req       = bus.rd | bus.wr;
  assign illegal   = (bus.rd & bus.wr) | (req & bus.addr[ALIGN_BIT]);
  assign legal     = req & ~illegal;
  assign bank_busy = busy_vec[bank];

  // WAIT is only reachable from a legal request that the requester keeps stable.
  assign accept = ((state == S_IDLE && legal) || state == S_WAIT) && !bank_busy;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign we[b] = accept & bus.wr & (bank == 2'(b));

    dmem_bank #(
      .ROW_BITS  (ROW_BITS),
      .BANK_BUSY (BANK_BUSY)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (we[b]),
      .row   (row),
      .wdata (bus.data_in),
      .rdata (rdata[b]),
      .busy  (busy_vec[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_cnt <= 4'(LATENCY - 1);
            state   <= S_ACCESS;
          end else if (legal) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (accept) begin
            lat_cnt <= 4'(LATENCY - 1);
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_cnt == '0) begin
            if (bus.rd) begin
              data_q <= rdata[bank];
            end
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = data_q;
  assign bus.done     = (state == S_DONE);
  assign bus.err      = (state == S_IDLE) && illegal;
  assign bus.stall    = (state == S_IDLE && legal) || state == S_WAIT || state == S_ACCESS;
  assign bus.busy     = busy_vec;

endmodule
